// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 DVP test-pattern generator.
package ov7670_pkg;

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      VBACK,
      ACTIVE,
      VFRONT
   } gen_state_t;

   typedef enum logic [1:0] {
      PAT_HRAMP,
      PAT_VRAMP,
      PAT_CHECKER,
      PAT_CONST
   } pattern_t;

   localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;
   localparam int         CNT_W          = 16;

endpackage

// File: rtl/ov7670_dvp_gen_pattern.sv
// Registered luma generator; advances only on update edges, fed with
// coordinates one PCLK ahead so its output lines up with the current byte.
module ov7670_pattern
   import ov7670_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       upd,
   input  pattern_t   mode,
   input  logic [7:0] const_y,
   input  logic [7:0] x,
   input  logic [7:0] y,
   output logic [7:0] y_pat
);

   logic [7:0] y_pat_q, y_pat_d;

   always_comb begin
      y_pat_d = y_pat_q;
      if (upd) begin
         unique case (mode)
            PAT_HRAMP:   y_pat_d = x;
            PAT_VRAMP:   y_pat_d = y;
            PAT_CHECKER: y_pat_d = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            PAT_CONST:   y_pat_d = const_y;
            default:     y_pat_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) y_pat_q <= '0;
      else     y_pat_q <= y_pat_d;
   end

   assign y_pat = y_pat_q;

endmodule

// File: rtl/ov7670_dvp_gen.sv
// OV7670 DVP transmitter: PCLK = clk/2, VGA-style YUYV frame timing with test patterns.
//
// state  | meaning
// IDLE   | waiting for enable, outputs low
// VSYNC  | VSYNC_LINES lines with vsync high
// VBACK  | VBACK_LINES blank lines
// ACTIVE | HEIGHT lines, href high for the first 2*WIDTH PCLK of each
// VFRONT | VFRONT_LINES blank lines, frame ends on the last one
module ov7670_dvp_gen
   import ov7670_pkg::*;
#(
   parameter int WIDTH        = 640,
   parameter int HEIGHT       = 480,
   parameter int HBLANK       = 288,
   parameter int VSYNC_LINES  = 3,
   parameter int VBACK_LINES  = 17,
   parameter int VFRONT_LINES = 10
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  mode,
   input  logic [7:0]  const_y,
   output logic        pclk,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  d,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(2*WIDTH + HBLANK - 1);
   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(2*WIDTH);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   function automatic logic [CNT_W-1:0] line_last(input gen_state_t s);
      case (s)
         VSYNC:   return CNT_W'(VSYNC_LINES - 1);
         VBACK:   return CNT_W'(VBACK_LINES - 1);
         ACTIVE:  return CNT_W'(HEIGHT - 1);
         VFRONT:  return CNT_W'(VFRONT_LINES - 1);
         default: return '0;
      endcase
   endfunction

   gen_state_t       state_q, state_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
   logic             pclk_q, pclk_d;
   logic             vsync_q, vsync_d, href_q, href_d;
   logic [7:0]       d_q, d_d;
   logic             frame_done_q, frame_done_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   pattern_t         mode_q, mode_d;
   logic [7:0]       const_y_q, const_y_d;
   logic             upd, frame_end;
   logic [CNT_W-1:0] h_next, l_next;
   logic [7:0]       x_early, y_early, y_pat;

   // Update edge: the clk edge on which PCLK falls.
   assign upd    = pclk_q;
   assign pclk_d = ~pclk_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pclk_q       <= 1'b0;
         state_q      <= IDLE;
         hcnt_q       <= '0;
         lcnt_q       <= '0;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         d_q          <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
         mode_q       <= PAT_HRAMP;
         const_y_q    <= '0;
      end else begin
         pclk_q       <= pclk_d;
         state_q      <= state_d;
         hcnt_q       <= hcnt_d;
         lcnt_q       <= lcnt_d;
         vsync_q      <= vsync_d;
         href_q       <= href_d;
         d_q          <= d_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
         mode_q       <= mode_d;
         const_y_q    <= const_y_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      lcnt_d    = lcnt_q;
      frame_end = 1'b0;
      if (upd) begin
         if (state_q == IDLE) begin
            if (enable) state_d = VSYNC;
         end else if (hcnt_q != H_LAST) begin
            hcnt_d = hcnt_q + ONE;
         end else begin
            hcnt_d = '0;
            if (lcnt_q != line_last(state_q)) begin
               lcnt_d = lcnt_q + ONE;
            end else begin
               lcnt_d = '0;
               unique case (state_q)
                  VSYNC:  state_d = VBACK;
                  VBACK:  state_d = ACTIVE;
                  ACTIVE: state_d = VFRONT;
                  VFRONT: begin
                     frame_end = 1'b1;
                     state_d   = enable ? VSYNC : IDLE;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
      end
   end

   // Position one PCLK beyond hcnt_d, so the registered pattern is ready in time.
   always_comb begin
      h_next = (hcnt_d == H_LAST) ? '0 : hcnt_d + ONE;
      l_next = lcnt_d;
      if (hcnt_d == H_LAST)
         l_next = (lcnt_d == line_last(state_d)) ? '0 : lcnt_d + ONE;
      x_early = 8'(h_next >> 1);
      y_early = 8'(l_next);
   end

   ov7670_pattern u_pattern (
      .clk     (clk),
      .rst     (rst),
      .upd     (upd),
      .mode    (mode_q),
      .const_y (const_y_q),
      .x       (x_early),
      .y       (y_early),
      .y_pat   (y_pat)
   );

   always_comb begin
      vsync_d      = vsync_q;
      href_d       = href_q;
      d_d          = d_q;
      frame_done_d = frame_end;
      frame_cnt_d  = frame_cnt_q;
      mode_d       = mode_q;
      const_y_d    = const_y_q;
      if (upd) begin
         vsync_d = (state_d == VSYNC);
         href_d  = (state_d == ACTIVE) && (hcnt_d < H_ACT);
         d_d     = href_d ? (hcnt_d[0] ? CHROMA_NEUTRAL : y_pat) : 8'h00;
         if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;
         if (state_d == VSYNC && state_q != VSYNC) begin
            mode_d    = pattern_t'(mode);
            const_y_d = const_y;
         end
      end
   end

   assign pclk       = pclk_q;
   assign vsync      = vsync_q;
   assign href       = href_q;
   assign d          = d_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_dvp_gen.sv
// Scoreboard bench for ov7670_dvp_gen: a frame-position reference model predicts
// every update edge, a negedge monitor pops and compares against the DUT.
module tb_ov7670_dvp_gen;

   localparam int W  = 16;
   localparam int H  = 16;
   localparam int HB = 2;
   localparam int VS = 1;
   localparam int VB = 1;
   localparam int VF = 1;
   localparam int L  = 2*W + HB;
   localparam int FRAME     = (VS + VB + H + VF) * L;
   localparam int FRAME_CLK = 2 * FRAME;

   typedef struct packed {
      logic        vsync;
      logic        href;
      logic [7:0]  d;
      logic        fd;
      logic [15:0] cnt;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst, enable;
   logic [1:0]  mode;
   logic [7:0]  const_y;
   logic        pclk, vsync, href, frame_done;
   logic [7:0]  d;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad   = 0;

   ov7670_dvp_gen #(
      .WIDTH(W), .HEIGHT(H), .HBLANK(HB),
      .VSYNC_LINES(VS), .VBACK_LINES(VB), .VFRONT_LINES(VF)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .const_y(const_y),
      .pclk(pclk), .vsync(vsync), .href(href), .d(d),
      .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   obs_t sb[$];
   bit   pclk_m  = 1'b0;
   bit   run_m   = 1'b0;
   bit   rst_last = 1'b0;
   bit   started = 1'b0;
   int   pos_m   = 0;
   int   mode_m  = 0;
   logic [7:0]  cy_m = 8'h00;
   logic [15:0] cnt_m = 16'h0;

   function automatic obs_t model_out(bit run, int pos, int md, logic [7:0] cy,
                                      logic [15:0] cnt, bit fd);
      obs_t e;
      int line, h, x, y, yv;
      bit act;
      line = pos / L;
      h    = pos % L;
      x    = h / 2;
      y    = line - VS - VB;
      act  = run && line >= VS + VB && line < VS + VB + H;
      case (md)
         0:       yv = x % 256;
         1:       yv = y % 256;
         2:       yv = (((x / 8) % 2) != ((y / 8) % 2)) ? 255 : 0;
         default: yv = int'(cy);
      endcase
      e.vsync = run && line < VS;
      e.href  = act && h < 2*W;
      e.d     = e.href ? ((h % 2 == 1) ? 8'h80 : 8'(yv)) : 8'h00;
      e.fd    = fd;
      e.cnt   = cnt;
      return e;
   endfunction

   always @(posedge clk) begin
      bit upd, fd;
      started  = 1'b1;
      rst_last = rst;
      if (rst) begin
         pclk_m = 1'b0;
         run_m  = 1'b0;
         pos_m  = 0;
         cnt_m  = 16'h0;
         sb.delete();
      end else begin
         upd    = pclk_m;
         pclk_m = ~pclk_m;
         fd     = 1'b0;
         if (upd) begin
            if (!run_m) begin
               if (enable) begin
                  run_m = 1'b1; pos_m = 0; mode_m = int'(mode); cy_m = const_y;
               end
            end else if (pos_m == FRAME - 1) begin
               fd    = 1'b1;
               cnt_m = cnt_m + 16'd1;
               if (enable) begin
                  pos_m = 0; mode_m = int'(mode); cy_m = const_y;
               end else begin
                  run_m = 1'b0; pos_m = 0;
               end
            end else begin
               pos_m++;
            end
            sb.push_back(model_out(run_m, pos_m, mode_m, cy_m, cnt_m, fd));
         end
      end
   end

   // ---------------- monitor ----------------
   obs_t last_exp = '0;

   always @(negedge clk) begin
      obs_t act, exp;
      if (started) begin
         act = '{vsync, href, d, frame_done, frame_cnt};
         total++;
         if (pclk !== pclk_m) begin
            bad++;
            $display("FAIL pclk: got %b expected %b at %0t", pclk, pclk_m, $time);
         end
         if (rst_last) begin
            last_exp = '0;
            exp      = '0;
         end else if (sb.size() > 0) begin
            exp      = sb.pop_front();
            last_exp = exp;
         end else begin
            exp    = last_exp;
            exp.fd = 1'b0;
         end
         total++;
         if (act !== exp) begin
            bad++;
            $display("FAIL outputs(vs,href,d,fd,cnt): got %b %b %h %b %h expected %b %b %h %b %h at %0t",
                     act.vsync, act.href, act.d, act.fd, act.cnt,
                     exp.vsync, exp.href, exp.d, exp.fd, exp.cnt, $time);
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; enable = 1'b0; mode = 2'd0; const_y = 8'h00;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(5);

      // ramp frame; switch to constant mid-ACTIVE, takes effect next frame
      enable = 1'b1; mode = 2'd0;
      wait_clk(2*(VS+VB+4)*L);
      mode = 2'd3; const_y = 8'h5A;
      wait_clk(FRAME_CLK);
      mode = 2'd1;
      wait_clk(FRAME_CLK);
      mode = 2'd2;
      wait_clk(FRAME_CLK);
      // drop enable mid-frame: frame completes, then idle
      enable = 1'b0;
      wait_clk(FRAME_CLK + 50);

      for (int i = 0; i < 8; i++) begin
         mode    = 2'($urandom_range(0, 3));
         const_y = 8'($urandom);
         enable  = ($urandom_range(0, 3) != 0);
         wait_clk($urandom_range(100, 1600));
      end

      // reset mid-line, then restart from VSYNC
      enable = 1'b1; mode = 2'd0;
      wait_clk(FRAME_CLK + 2*(VS+VB+2)*L + 7);
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      wait_clk(FRAME_CLK + 40);
      enable = 1'b0;
      wait_clk(FRAME_CLK + 40);

      total++;
      if (cnt_m == 16'h0) begin
         bad++;
         $display("FAIL frames_completed: got %0d expected nonzero", cnt_m);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ov7670_dvp_gen.md
# ov7670_dvp_gen

- Synthesizable OV7670 DVP transmitter: camera side of the parallel pixel bus.
- Generates PCLK, VSYNC, HREF and D[7:0] with OV7670 VGA YUV422 frame timing, carrying selectable test patterns.
- Drives the capture path (ov7670_capture → fb1) in place of the sensor, for simulation and for on-board self-test behind a mux.

## Interface
Parameters:
- WIDTH, 640, active pixels per line (2 bytes per pixel)
- HEIGHT, 480, active lines per frame
- HBLANK, 288, PCLK periods with HREF low per line
- VSYNC_LINES, 3, lines with VSYNC high
- VBACK_LINES, 17, blank lines after VSYNC
- VFRONT_LINES, 10, blank lines after the last active line

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  generator clock; PCLK = clk/2
- rst  in  1  synchronous reset, active-high
- enable  in  1  run frames while high
- mode  in  2  pattern: 0 horizontal ramp, 1 vertical ramp, 2 checker, 3 constant
- const_y  in  8  luma value for mode 3
- pclk  out  1  pixel clock to receiver
- vsync  out  1  frame sync, active-high
- href  out  1  line valid, active-high
- d  out  8  pixel byte
- frame_done  out  1  one-clk pulse at the end of each frame
- frame_cnt  out  16  completed frames, wraps

## Operation
- PCLK toggles every clk from reset release and is free-running, including in IDLE.
- Update edge: a clk edge on which PCLK goes 1→0. vsync, href, d, state and counters change only on update edges, so they are stable across the PCLK rising edge.
- Line length: L = 2·WIDTH + HBLANK PCLK periods. Line counter hcnt runs 0..L-1.
- States and line counts:
  - IDLE: outputs low.
  - VSYNC: VSYNC_LINES lines, vsync=1.
  - VBACK: VBACK_LINES lines.
  - ACTIVE: HEIGHT lines.
  - VFRONT: VFRONT_LINES lines.
- State transitions:
  - IDLE→VSYNC on an update edge with enable=1.
  - VFRONT end → VSYNC if enable=1, else IDLE. Back-to-back frames have no gap.
  - enable is sampled only at frame start; deasserting it mid-frame completes the frame.
- ACTIVE line: href=1 for hcnt < 2·WIDTH, else 0.
  - Pixel x = hcnt>>1, row y = active line index.
  - Byte order YUYV: even hcnt = Y, odd hcnt = 8'h80.
- Y per mode:
  - 0: x[7:0] (wraps at 256).
  - 1: y[7:0].
  - 2: 8'hFF if x[3]^y[3], else 8'h00.
  - 3: const_y.
- mode and const_y are latched on entry to VSYNC; changes mid-frame take effect next frame.
- d=8'h00 whenever href=0.
- frame_done pulses 1 clk on the update edge that leaves VFRONT; frame_cnt increments on the same edge, wraps FFFF→0000.
- rst: on the next clk, pclk=0, vsync=0, href=0, d=0, frame_done=0, frame_cnt=0, state=IDLE, counters=0. Applies mid-line and mid-frame; no partial line is resumed.

## Timing
- Latency:
  - enable high → vsync rises at the first update edge (≤2 clk).
  - vsync falls exactly VSYNC_LINES·L PCLK periods later.
  - First href rises (VSYNC_LINES+VBACK_LINES)·L PCLK after vsync rise.
- Frame period: (VSYNC_LINES+VBACK_LINES+HEIGHT+VFRONT_LINES)·L PCLK = 2× that in clk.
- Defaults: L=1568, 510 lines/frame, 799,680 PCLK/frame.
- href high for exactly 2·WIDTH PCLK per active line; aligned to update edges, never glitches.
- d, href, vsync are registered outputs; no combinational path from inputs.

## Structure
- Package ov7670_pkg:
  - gen_state_t enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT).
  - pattern_t enum for mode.
  - CHROMA_NEUTRAL = 8'h80.
- Sub-module ov7670_pattern:
  - Registered Y from (x, y, latched mode, latched const_y).
  - One update-edge latency, compensated by issuing hcnt one PCLK early.
- Top ov7670_dvp_gen: PCLK divider, FSM, hcnt/line counters, output registers.

## Test plan
Sim params: WIDTH=4, HEIGHT=3, HBLANK=2, VSYNC=1, VBACK=1, VFRONT=1 (L=10).
- Reset → pclk/vsync/href/d/frame_done/frame_cnt all 0 next clk; pclk toggles after release.
- mode=0, enable=1 → each active line, sampled on PCLK rise: 00 80 01 80 02 80 03 80; href high 8 PCLK then low 2; 3 lines.
- Frame timing:
  - vsync high 10 PCLK.
  - first href 20 PCLK after vsync rise.
  - frame 60 PCLK.
  - single frame_done pulse; frame_cnt=1.
- mode=2 with WIDTH=16, HEIGHT=16 → bytes FF/00 flip every 8 pixels and every 8 lines.
- Mode switched 0→3 (const_y=5A) mid-ACTIVE → frame stays ramp; next frame Y=5A.
- enable dropped mid-ACTIVE → frame completes, frame_cnt increments, then IDLE.
- rst asserted mid-line → all outputs 0 next clk; on release, restart from VSYNC.
- Loopback into ov7670_capture → fb1 holds the expected ramp.
